// File: rtl/multi_edge_detect.sv
// Multi-channel synchronising edge detector with per-channel sticky event flags and irq.
// Define EDGE_DEBOUNCE_EN to add a per-channel debounce counter of DB_CYCLES clocks.
module multi_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     d,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     rise,
  output logic [WIDTH-1:0]     fall,
  output logic [WIDTH-1:0]     toggle,
  output logic [WIDTH-1:0]     event_flag,
  output logic                 irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH out of range 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_bad_db
    $error("DB_CYCLES out of range 1..15");
  end

  typedef enum logic {WARMUP, RUN} state_t;

`ifdef EDGE_DEBOUNCE_EN
  // The debounced value register is one more pipeline stage to flush before RUN.
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);
`else
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES);
`endif

  state_t                       state, state_next;
  logic [2:0]                   warm_cnt, warm_cnt_next;
  logic [SYNC_STAGES*WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0]             v;
  logic [WIDTH-1:0]             p;
  logic [WIDTH-1:0]             qual;
  logic                         run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    if (state == WARMUP) begin
      if (warm_cnt == WARM_LAST) begin
        state_next    = RUN;
        warm_cnt_next = '0;
      end else begin
        warm_cnt_next = warm_cnt + 3'd1;
      end
    end
  end

  assign run = (state == RUN);

  // Lowest WIDTH bits are stage 0; d feeds nothing but that stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[(SYNC_STAGES-1)*WIDTH-1:0], d};
    end
  end

  assign s = sync_chain[SYNC_STAGES*WIDTH-1 -: WIDTH];

`ifdef EDGE_DEBOUNCE_EN
  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    logic [3:0] db_cnt;
    logic       v_bit;

    // During WARMUP v follows s directly so a level held through reset gives no pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt <= '0;
        v_bit  <= 1'b0;
      end else if (!run) begin
        db_cnt <= '0;
        v_bit  <= s[gi];
      end else if (s[gi] == v_bit) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        v_bit  <= s[gi];
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end

    assign v[gi] = v_bit;
  end
`else
  assign v = s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p <= '0;
    end else begin
      p <= v;
    end
  end

  assign rise   = run ? (v & ~p) : '0;
  assign fall   = run ? (~v & p) : '0;
  assign toggle = run ? (v ^ p)  : '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qual
    assign qual[gi] = (mode[2*gi] & rise[gi]) | (mode[2*gi+1] & fall[gi]);
  end

  // A qualifying pulse in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_flag <= '0;
    end else begin
      event_flag <= (event_flag & ~clr) | qual;
    end
  end

  assign irq = |event_flag;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect in its default build (WIDTH=8, SYNC_STAGES=2).
module tb_multi_edge_detect;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  d;
  logic [15:0] mode;
  logic [7:0]  clr;
  logic [7:0]  rise;
  logic [7:0]  fall;
  logic [7:0]  toggle;
  logic [7:0]  event_flag;
  logic        irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_edge_detect #(.WIDTH(8), .SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d          (d),
    .mode       (mode),
    .clr        (clr),
    .rise       (rise),
    .fall       (fall),
    .toggle     (toggle),
    .event_flag (event_flag),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pulses(input string tag, input logic [7:0] r, input logic [7:0] f,
                              input logic [7:0] t);
    check({tag, ".rise"}, 32'(rise), 32'(r));
    check({tag, ".fall"}, 32'(fall), 32'(f));
    check({tag, ".toggle"}, 32'(toggle), 32'(t));
  endtask

  initial begin
    reset_n = 1'b0;
    d       = 8'hFF;
    mode    = 16'hFFFF;
    clr     = 8'h00;
    step();
    step();
    check_pulses("in_reset", 8'h00, 8'h00, 8'h00);
    check("in_reset.flag", 32'(event_flag), 32'h0);
    check("in_reset.irq", 32'(irq), 32'h0);

    // Level 0xFF held through reset release must never pulse.
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_pulses($sformatf("warm%0d", i), 8'h00, 8'h00, 8'h00);
      check($sformatf("warm%0d.flag", i), 32'(event_flag), 32'h0);
      check($sformatf("warm%0d.irq", i), 32'(irq), 32'h0);
    end

    // All channels fall with mode off: pulses but no flags.
    mode = 16'h0000;
    d    = 8'h00;
    step();
    check_pulses("off_e1", 8'h00, 8'h00, 8'h00);
    step();
    check_pulses("off_e2", 8'h00, 8'hFF, 8'hFF);
    step();
    check_pulses("off_e3", 8'h00, 8'h00, 8'h00);
    check("off_e3.flag", 32'(event_flag), 32'h0);

    // ch0 any edge, ch1 rise only; both rise.
    mode = 16'h0007;
    d    = 8'h03;
    step();
    step();
    check_pulses("rise_e2", 8'h03, 8'h00, 8'h03);
    check("rise_e2.flag", 32'(event_flag), 32'h0);
    step();
    check_pulses("rise_e3", 8'h00, 8'h00, 8'h00);
    check("rise_e3.flag", 32'(event_flag), 32'h03);
    check("rise_e3.irq", 32'(irq), 32'h1);

    clr = 8'h02;
    step();
    check("clr1.flag", 32'(event_flag), 32'h01);
    clr = 8'h00;

    // ch1 falls; rise-only mode must not set its flag.
    d = 8'h01;
    step();
    step();
    check_pulses("fall1_e2", 8'h00, 8'h02, 8'h02);
    step();
    check("fall1_e3.flag", 32'(event_flag), 32'h01);
    check("fall1_e3.irq", 32'(irq), 32'h1);

    d = 8'h00;
    step();
    step();
    step();
    check("ch0_fall.flag", 32'(event_flag), 32'h01);

    // clr coincident with a qualifying rise: set wins; clr alone then clears.
    d = 8'h01;
    step();
    step();
    check_pulses("race_e2", 8'h01, 8'h00, 8'h01);
    clr = 8'h01;
    step();
    check("race.flag", 32'(event_flag), 32'h01);
    step();
    check("clr0.flag", 32'(event_flag), 32'h00);
    check("clr0.irq", 32'(irq), 32'h0);
    clr = 8'h00;

    // ch2 toggles every clock: one pulse per cycle, alternating direction.
    for (int i = 0; i < 6; i++) begin
      d[2] = ~d[2];
      step();
      if (i >= 1) begin
        check($sformatf("tog%0d.toggle2", i), 32'(toggle[2]), 32'h1);
        check($sformatf("tog%0d.rise2", i), 32'(rise[2]), 32'((i % 2) == 1));
      end
    end
    step();
    check("tog_last.toggle2", 32'(toggle[2]), 32'h1);
    step();
    step();
    check("tog_done.toggle", 32'(toggle), 32'h0);
    check("tog_done.flag", 32'(event_flag), 32'h0);

    // Build flags 0x05, then reset asynchronously with a fall pending on ch2.
    mode = 16'h0033;
    d    = 8'h04;
    step();
    step();
    step();
    check("pre_rst.flag", 32'(event_flag), 32'h05);
    check("pre_rst.irq", 32'(irq), 32'h1);
    d = 8'h00;
    step();
    #3 reset_n = 1'b0;
    #1;
    check("async_rst.flag", 32'(event_flag), 32'h00);
    check("async_rst.irq", 32'(irq), 32'h0);
    check_pulses("async_rst", 8'h00, 8'h00, 8'h00);
    step();
    reset_n = 1'b1;
    d       = 8'h04;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rewarm%0d.toggle", i), 32'(toggle), 32'h0);
      check($sformatf("rewarm%0d.flag", i), 32'(event_flag), 32'h0);
    end

    d = 8'h00;
    step();
    step();
    check_pulses("restart_e2", 8'h00, 8'h04, 8'h04);
    step();
    check("restart_e3.flag", 32'(event_flag), 32'h04);
    check("restart_e3.irq", 32'(irq), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
